mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Moore-style control FSM for the multicycle build of the MIPS core. It sits directly upstream of the multicycle datapath. It consumes opcode, funct and ALU zero, and drives every mux select, write enable and ALU control the datapath needs, one micro-step per clock. It replaces the single-cycle combinational controller. Instruction set: R-type (add/sub/and/or/slt), lw, sw, beq, addi, ori, j.

Parameters:
STATE_W, 4, width of state register and debug state port

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
pcen  out  1  PC register enable = pcwrite | (branch & zero)
memwrite  out  1  data memory write enable
irwrite  out  1  instruction register load enable
regwrite  out  1  register file write enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memtoreg  out  1  write-back select: 0 = ALUOut, 1 = data register
regdst  out  1  destination select: 0 = rt, 1 = rd
alusrca  out  1  ALU A select: 0 = PC, 1 = rs
alusrcb  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = extended imm, 11 = imm<<2
pcsrc  out  2  next PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal_op  out  1  one-cycle pulse when an unsupported op or funct is decoded
state  out  STATE_W  current state, for debug and verification

Behaviour:
- Reset is asynchronous, active-high. State goes to FETCH(0) immediately. While reset is high, pcen, memwrite, irwrite and regwrite are forced to 0. All other outputs show their FETCH values. The first FETCH executes on the first rising edge after reset deasserts.
- State register: one per clock. All outputs are decoded from the state register only (Moore), except two:
  - pcen uses zero combinationally.
  - alucontrol in RTYPEEX decodes funct.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, IMMWB 10, JEX 11, ORIEX 12. Codes 13-15 go to FETCH on the next edge and pulse illegal_op.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 001101 -> ORIEX; 000010 -> JEX; any other op -> FETCH with illegal_op=1 in DECODE.
  - MEMADR -> MEMRD if op=100011, MEMWR if op=101011.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX and ORIEX -> IMMWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, IMMWB, JEX -> FETCH.
- Per-state outputs (unlisted: 0; alucontrol 010):
  - FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, add.
  - MEMADR: alusrca=1, alusrcb=10, add.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt).
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
  - BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, add.
  - ORIEX: alusrca=1, alusrcb=10, or. Zero extension is done by the datapath on op 001101.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- Unsupported funct with op=000000: detected in DECODE. Next state is FETCH with illegal_op=1; no register write occurs.
- CPI: lw 5, sw 4, R-type 4, addi 4, ori 4, beq 3, j 3.
- Reset mid-instruction: any state returns to FETCH immediately, and no write enable is asserted during or after the reset edge.

Test Plan:
- Reset held 3 cycles in MEMWR -> state=0 and memwrite=0 at once; after release, the first edge gives state=1, and pcen=1 and irwrite=1 during FETCH.
- op=100011 -> state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. iord=1 only in state 3.
- op=000000, funct=101010 -> states 0,1,6,7,0. alucontrol=111 in state 6. regdst=1 and regwrite=1 in state 7.
- op=000100 with zero=1 -> pcen=1, pcsrc=01, alucontrol=110 in BEQEX. Repeat with zero=0 -> pcen=0. Both return to FETCH.
- op=001101 -> states 0,1,12,10,0 with alusrcb=10 and alucontrol=001 in state 12. op=000010 -> states 0,1,11,0 with pcsrc=10, pcen=1.
- op=111111, then op=000000 with funct=000111 -> illegal_op pulses one cycle in DECODE, next state=0, and no regwrite or memwrite occurs.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: one micro-step per clock, Moore-decoded datapath controls.
// pcen (branch & zero) and the R-type ALU function are the only combinational paths.
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 0,
        DECODE  = 1,
        MEMADR  = 2,
        MEMRD   = 3,
        MEMWB   = 4,
        MEMWR   = 5,
        RTYPEEX = 6,
        RTYPEWB = 7,
        BEQEX   = 8,
        ADDIEX  = 9,
        IMMWB   = 10,
        JEX     = 11,
        ORIEX   = 12
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctl;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                               funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c        = '0;
        c.aluctl = ALU_ADD;
        case (s)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: c.alusrca = 1'b1;
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluctl  = ALU_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ORIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluctl  = ALU_OR;
            end
            IMMWB:   c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c.aluctl = ALU_ADD;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_ok(funct) ? RTYPEEX : FETCH;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_ORI:       state_d = ORIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)      state_d = MEMRD;
                else if (op == OP_SW) state_d = MEMWR;
                else                  state_d = FETCH;
            end
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = IMMWB;
            ORIEX:   state_d = IMMWB;
            default: state_d = FETCH;
        endcase
    end

    // Controls are registered from the next state so they line up with state_q;
    // reset loads the FETCH pattern and the write enables are gated by reset below.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= decode(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

    always_comb begin
        illegal_op = 1'b0;
        case (state_q)
            DECODE: begin
                case (op)
                    OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: illegal_op = 1'b0;
                    OP_RTYPE: illegal_op = ~funct_ok(funct);
                    default:  illegal_op = 1'b1;
                endcase
            end
            FETCH, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
            BEQEX, ADDIEX, IMMWB, JEX, ORIEX: illegal_op = 1'b0;
            default: illegal_op = 1'b1;
        endcase
    end

    assign pcen       = (ctrl_q.pcwrite | (ctrl_q.branch & zero)) & ~reset;
    assign memwrite   = ctrl_q.memwrite & ~reset;
    assign irwrite    = ctrl_q.irwrite & ~reset;
    assign regwrite   = ctrl_q.regwrite & ~reset;
    assign iord       = ctrl_q.iord;
    assign memtoreg   = ctrl_q.memtoreg;
    assign regdst     = ctrl_q.regdst;
    assign alusrca    = ctrl_q.alusrca;
    assign alusrcb    = ctrl_q.alusrcb;
    assign pcsrc      = ctrl_q.pcsrc;
    assign alucontrol = (state_q == RTYPEEX) ? funct_alu(funct) : ctrl_q.aluctl;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: instruction-level model predicts every cycle's outputs.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    logic [19:0] expq[$];
    int          tagq[$];

    mc_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit r_legal(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic bit op_legal(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    // Expected output vector for one micro-step, straight from the per-state table.
    function automatic logic [19:0] exp_out(input int st, input logic [5:0] o,
                                            input logic [5:0] f, input logic z);
        logic pc, mw, ir, rw, io, mr, rd, sa, il;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {pc, mw, ir, rw, io, mr, rd, sa, il} = '0;
        sb = 2'b00;
        ps = 2'b00;
        ac = 3'b010;
        case (st)
            0:  begin pc = 1; ir = 1; sb = 2'b01; end
            1:  begin sb = 2'b11; il = !op_legal(o) || (o == 6'b000000 && !r_legal(f)); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin mr = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; ac = r_alu(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pc = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pc = 1; end
            12: begin sa = 1; sb = 2'b10; ac = 3'b001; end
            default: il = 1;
        endcase
        return {4'(st), pc, mw, ir, rw, io, mr, rd, sa, sb, ps, ac, il};
    endfunction

    // Issue one instruction: predict its state path, queue every cycle, then step through it.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        int p[$];
        if (o == 6'b100011)                        p = '{0, 1, 2, 3, 4};
        else if (o == 6'b101011)                   p = '{0, 1, 2, 5};
        else if (o == 6'b000000 && r_legal(f))     p = '{0, 1, 6, 7};
        else if (o == 6'b000100)                   p = '{0, 1, 8};
        else if (o == 6'b001000)                   p = '{0, 1, 9, 10};
        else if (o == 6'b001101)                   p = '{0, 1, 12, 10};
        else if (o == 6'b000010)                   p = '{0, 1, 11};
        else                                       p = '{0, 1};
        op    = o;
        funct = f;
        zero  = z;
        foreach (p[i]) begin
            expq.push_back(exp_out(p[i], o, f, z));
            tagq.push_back(p[i]);
        end
        repeat (p.size()) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin : monitor
        logic [19:0] e, a;
        int          t;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                t = tagq.pop_front();
                a = {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
                     alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL step_state%0d op=%b funct=%b zero=%b: got %h want %h",
                             t, op, funct, zero, a, e);
                end
            end
        end
    end

    initial begin : stimulus
        logic [5:0] rf[5];
        logic [5:0] lo[7];
        logic [5:0] o, f;
        int         k;
        rf = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        lo = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
        reset = 1'b1;
        op    = '0;
        funct = '0;
        zero  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Walk an sw into MEMWR unscored, then reset there.
        op = 6'b101011;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_state", 32'(state), 32'd5);
        check("pre_reset_memwrite", 32'(memwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_we", 32'({pcen, memwrite, irwrite, regwrite}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", 32'({state, pcen, memwrite, irwrite, regwrite, alusrcb}),
                  32'({4'd0, 4'b0000, 2'b01}));
        end
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(6'b100011, 6'b000000, 1'b0);
        run_instr(6'b000000, 6'b101010, 1'b0);
        run_instr(6'b000100, 6'b000000, 1'b1);
        run_instr(6'b000100, 6'b000000, 1'b0);
        run_instr(6'b001101, 6'b000000, 1'b0);
        run_instr(6'b000010, 6'b000000, 1'b1);
        run_instr(6'b111111, 6'b000000, 1'b0);
        run_instr(6'b000000, 6'b000111, 1'b0);
        run_instr(6'b101011, 6'b010101, 1'b1);
        run_instr(6'b001000, 6'b100000, 1'b0);

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            f = 6'($urandom);
            if (k < 7) begin
                o = lo[k];
                if (k == 0) f = rf[$urandom_range(0, 4)];
            end else if (k == 7) begin
                o = 6'($urandom);
                while (op_legal(o)) o = 6'($urandom);
            end else begin
                o = 6'b000000;
                while (r_legal(f)) f = 6'($urandom);
            end
            run_instr(o, f, 1'($urandom));
        end

        for (int w = 0; w < 20 && expq.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        if (expq.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
